t01_ai_move_scheduler: RTL

- Sequences the AI placement search.
  - Walks every (rotation, column) candidate.
  - Requests the placement unit to build the candidate board.
  - Drives the feature extractor's start/ready handshake.
  - Scores the four returned features with fixed weights and keeps the best candidate.
- Sits between the game FSM, which requests a move, and the placement unit plus feature extractor pair. The candidate board is wired from the placement unit directly to the extractor, not through this block.

---
 rtl/t01_ai_pkg.sv | 30 +++
 rtl/t01_ai_move_scheduler_if.sv | 42 ++++
 rtl/t01_ai_move_scheduler_score_calc.sv | 39 +++
 rtl/t01_ai_move_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/t01_ai_pkg.sv
// Shared types and constants for the AI placement search scheduler.
package t01_ai_pkg;

  localparam int unsigned NUM_ROT_DEF = 4;
  localparam int unsigned NUM_COL_DEF = 10;

  localparam logic [7:0] W_LINES_DEF  = 8'd76;
  localparam logic [7:0] W_HOLES_DEF  = 8'd36;
  localparam logic [7:0] W_BUMP_DEF   = 8'd18;
  localparam logic [7:0] W_HEIGHT_DEF = 8'd51;

  localparam int unsigned SCORE_W = 20;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  // Cycles during which a stale ext_ready from the previous candidate is ignored.
  localparam logic [1:0] GUARD_CYCLES = 2'd2;

  typedef enum logic [3:0] {
    StIdle,
    StPlaceReq,
    StPlaceWait,
    StExtStart,
    StExtWait,
    StExtRelease,
    StScore,
    StNext,
    StDone
  } sched_state_t;

endpackage

// File: rtl/t01_ai_move_scheduler_if.sv
// Bundle of the game-FSM, placement-unit and extractor signals seen by the scheduler.
interface t01_ai_move_scheduler_if;
  import t01_ai_pkg::*;

  logic                      search_start;
  logic                      search_busy;
  logic                      search_done;
  logic [1:0]                best_rot;
  logic [3:0]                best_col;
  logic signed [SCORE_W-1:0] best_score;
  logic                      best_valid;

  logic [1:0]                cand_rot;
  logic [3:0]                cand_col;
  logic                      place_req;
  logic                      place_valid;
  logic                      place_legal;

  logic                      ext_start;
  logic                      ext_ready;
  logic [2:0]                ext_lines;
  logic [7:0]                ext_holes;
  logic [7:0]                ext_bump;
  logic [7:0]                ext_height;

  // Scheduler side.
  modport master (
    input  search_start, place_valid, place_legal,
    input  ext_ready, ext_lines, ext_holes, ext_bump, ext_height,
    output search_busy, search_done, best_rot, best_col, best_score, best_valid,
    output cand_rot, cand_col, place_req, ext_start
  );

  // Game FSM, placement unit and extractor side.
  modport slave (
    output search_start, place_valid, place_legal,
    output ext_ready, ext_lines, ext_holes, ext_bump, ext_height,
    input  search_busy, search_done, best_rot, best_col, best_score, best_valid,
    input  cand_rot, cand_col, place_req, ext_start
  );

endinterface

// File: rtl/t01_ai_move_scheduler_score_calc.sv
// Combinational weighted board score; all operands zero-extended before signed math.
module t01_ai_score_calc
  import t01_ai_pkg::*;
#(
  parameter logic [7:0] W_LINES  = W_LINES_DEF,
  parameter logic [7:0] W_HOLES  = W_HOLES_DEF,
  parameter logic [7:0] W_BUMP   = W_BUMP_DEF,
  parameter logic [7:0] W_HEIGHT = W_HEIGHT_DEF
) (
  input  logic [2:0]                i_lines,
  input  logic [7:0]                i_holes,
  input  logic [7:0]                i_bump,
  input  logic [7:0]                i_height,
  output logic signed [SCORE_W-1:0] o_score
);

  logic signed [SCORE_W-1:0] w_lines;
  logic signed [SCORE_W-1:0] w_holes;
  logic signed [SCORE_W-1:0] w_bump;
  logic signed [SCORE_W-1:0] w_height;
  logic signed [SCORE_W-1:0] w_wt_lines;
  logic signed [SCORE_W-1:0] w_wt_holes;
  logic signed [SCORE_W-1:0] w_wt_bump;
  logic signed [SCORE_W-1:0] w_wt_height;

  assign w_lines     = $signed({{(SCORE_W-3){1'b0}}, i_lines});
  assign w_holes     = $signed({{(SCORE_W-8){1'b0}}, i_holes});
  assign w_bump      = $signed({{(SCORE_W-8){1'b0}}, i_bump});
  assign w_height    = $signed({{(SCORE_W-8){1'b0}}, i_height});
  assign w_wt_lines  = $signed({{(SCORE_W-8){1'b0}}, W_LINES});
  assign w_wt_holes  = $signed({{(SCORE_W-8){1'b0}}, W_HOLES});
  assign w_wt_bump   = $signed({{(SCORE_W-8){1'b0}}, W_BUMP});
  assign w_wt_height = $signed({{(SCORE_W-8){1'b0}}, W_HEIGHT});

  // Worst case magnitude is 3*255*255, well inside SCORE_W bits.
  assign o_score = w_lines * w_wt_lines - w_holes * w_wt_holes
                 - w_bump * w_wt_bump - w_height * w_wt_height;

endmodule

// File: rtl/t01_ai_move_scheduler.sv
// Walks every (rotation, column) candidate, drives placement and feature extraction,
// and keeps the best-scoring legal candidate (earliest wins on ties).
module t01_ai_move_scheduler
  import t01_ai_pkg::*;
#(
  parameter int unsigned NUM_ROT  = NUM_ROT_DEF,
  parameter int unsigned NUM_COL  = NUM_COL_DEF,
  parameter logic [7:0]  W_LINES  = W_LINES_DEF,
  parameter logic [7:0]  W_HOLES  = W_HOLES_DEF,
  parameter logic [7:0]  W_BUMP   = W_BUMP_DEF,
  parameter logic [7:0]  W_HEIGHT = W_HEIGHT_DEF
) (
  input logic                    clk,
  input logic                    reset,
  t01_ai_move_scheduler_if.master bus
);

  sched_state_t r_state;
  sched_state_t w_state_d;

  logic [1:0]                r_rot;
  logic [3:0]                r_col;
  logic [1:0]                r_guard;
  logic [2:0]                r_lines;
  logic [7:0]                r_holes;
  logic [7:0]                r_bump;
  logic [7:0]                r_height;
  logic [1:0]                r_best_rot;
  logic [3:0]                r_best_col;
  logic signed [SCORE_W-1:0] r_best_score;
  logic                      r_best_valid;

  logic                      w_score_en;
  logic signed [SCORE_W-1:0] w_score;
  logic                      w_last_col;
  logic                      w_last_cand;
  logic                      w_place_req;
  logic                      w_ext_start;
  logic                      w_busy;
  logic                      w_done;

  assign w_last_col  = (r_col == 4'(NUM_COL - 1));
  assign w_last_cand = w_last_col && (r_rot == 2'(NUM_ROT - 1));

  t01_ai_score_calc #(
    .W_LINES  (W_LINES),
    .W_HOLES  (W_HOLES),
    .W_BUMP   (W_BUMP),
    .W_HEIGHT (W_HEIGHT)
  ) u_score_calc (
    .i_lines  (r_lines),
    .i_holes  (r_holes),
    .i_bump   (r_bump),
    .i_height (r_height),
    .o_score  (w_score)
  );

  always_comb begin
    w_state_d   = r_state;
    w_place_req = 1'b0;
    w_ext_start = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_score_en  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        if (bus.search_start) w_state_d = StPlaceReq;
      end
      StPlaceReq: begin
        w_place_req = 1'b1;
        w_state_d   = StPlaceWait;
      end
      StPlaceWait: begin
        if (bus.place_valid) w_state_d = bus.place_legal ? StExtStart : StNext;
      end
      StExtStart: begin
        w_ext_start = 1'b1;
        w_state_d   = StExtWait;
      end
      StExtWait: begin
        w_ext_start = 1'b1;
        if ((r_guard == 2'd0) && bus.ext_ready) w_state_d = StExtRelease;
      end
      StExtRelease: w_state_d = StScore;
      StScore: begin
        w_score_en = 1'b1;
        w_state_d  = StNext;
      end
      StNext: w_state_d = w_last_cand ? StDone : StPlaceReq;
      StDone: begin
        w_busy    = 1'b0;
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_busy    = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rot        <= '0;
      r_col        <= '0;
      r_guard      <= '0;
      r_lines      <= '0;
      r_holes      <= '0;
      r_bump       <= '0;
      r_height     <= '0;
      r_best_rot   <= '0;
      r_best_col   <= '0;
      r_best_score <= SCORE_MIN;
      r_best_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.search_start) begin
            r_rot        <= '0;
            r_col        <= '0;
            r_best_rot   <= '0;
            r_best_col   <= '0;
            r_best_score <= SCORE_MIN;
            r_best_valid <= 1'b0;
          end
        end
        StExtStart: r_guard <= GUARD_CYCLES;
        StExtWait: begin
          if (r_guard != 2'd0) begin
            r_guard <= r_guard - 2'd1;
          end else if (bus.ext_ready) begin
            r_lines  <= bus.ext_lines;
            r_holes  <= bus.ext_holes;
            r_bump   <= bus.ext_bump;
            r_height <= bus.ext_height;
          end
        end
        StScore: begin
          // Strictly greater keeps the earliest candidate on ties.
          if (w_score_en && (w_score > r_best_score)) begin
            r_best_rot   <= r_rot;
            r_best_col   <= r_col;
            r_best_score <= w_score;
            r_best_valid <= 1'b1;
          end
        end
        StNext: begin
          if (w_last_col) begin
            r_col <= '0;
            r_rot <= r_rot + 2'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.search_busy = w_busy;
  assign bus.search_done = w_done;
  assign bus.best_rot    = r_best_rot;
  assign bus.best_col    = r_best_col;
  assign bus.best_score  = r_best_score;
  assign bus.best_valid  = r_best_valid;
  assign bus.cand_rot    = r_rot;
  assign bus.cand_col    = r_col;
  assign bus.place_req   = w_place_req;
  assign bus.ext_start   = w_ext_start;

endmodule
